// File: rtl/fpu_wb_stage.sv
// FPU writeback stage: valid/ready capture of result, op and overflow into a DEPTH-entry FIFO.
// Latency: 1 cycle from push into an empty FIFO to out_valid. Backpressure: in_ready=!full, even if popping.
// Optional FPU_WB_CLASSIFY_EN stores a {nan,inf,zero,denorm} class with each entry.
module fpu_wb_stage #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [31:0]      in_result,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [3:0]       out_op,
  output logic             out_ovf,
  output logic [3:0]       out_class,
  input  logic             clr_sticky,
  output logic             sticky_ovf,
  output logic [CNT_W-1:0] retired_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

`ifdef FPU_WB_CLASSIFY_EN
  typedef struct packed {
    logic [3:0]  op;
    logic        ovf;
    logic [31:0] result;
    logic [3:0]  cls;
  } entry_t;
`else
  typedef struct packed {
    logic [3:0]  op;
    logic        ovf;
    logic [31:0] result;
  } entry_t;
`endif

  entry_t        mem [DEPTH];
  entry_t        in_entry;
  entry_t        head_q;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd_nxt;
  logic [PW:0]   count;
  logic [PW:0]   count_nxt;
  logic          push;
  logic          pop;
  logic          head_from_in;

  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    in_entry        = '0;
    in_entry.op     = in_op;
    in_entry.ovf    = in_ovf;
    in_entry.result = in_result;
`ifdef FPU_WB_CLASSIFY_EN
    in_entry.cls[3] = (in_result[30:23] == 8'hFF) && (in_result[22:0] != '0);
    in_entry.cls[2] = (in_result[30:23] == 8'hFF) && (in_result[22:0] == '0);
    in_entry.cls[1] = (in_result[30:23] == 8'h00) && (in_result[22:0] == '0);
    in_entry.cls[0] = (in_result[30:23] == 8'h00) && (in_result[22:0] != '0);
`endif
  end

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (PW+1)'(1);
      2'b01:   count_nxt = count - (PW+1)'(1);
      default: count_nxt = count;
    endcase
    rd_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;
    // The incoming entry bypasses storage when nothing older remains after this cycle's pop.
    head_from_in = push && ((count == '0) || ((count == (PW+1)'(1)) && pop));
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head_q      <= '0;
      sticky_ovf  <= 1'b0;
      retired_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      rd_ptr <= rd_nxt;
      count  <= count_nxt;
      // Head register keeps the last entry visible once the FIFO drains.
      if (count_nxt != '0) head_q <= head_from_in ? in_entry : mem[rd_nxt];
      if (push && in_ovf)  sticky_ovf <= 1'b1;
      else if (clr_sticky) sticky_ovf <= 1'b0;
      if (pop && (retired_cnt != {CNT_W{1'b1}})) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  assign out_data = head_q.result;
  assign out_op   = head_q.op;
  assign out_ovf  = head_q.ovf;
`ifdef FPU_WB_CLASSIFY_EN
  assign out_class = head_q.cls;
`else
  assign out_class = 4'b0000;
`endif

endmodule

// File: tb/tb_fpu_wb_stage.sv
// Directed bench for fpu_wb_stage (CNT_W=4 so counter saturation is reachable).
module tb_fpu_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_result;
  logic        in_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_op;
  logic        out_ovf;
  logic [3:0]  out_class;
  logic        clr_sticky;
  logic        sticky_ovf;
  logic [3:0]  retired_cnt;

  int tests = 0;
  int fails = 0;
  int exp_ret = 0;
  logic [3:0] exp_cls;

  fpu_wb_stage #(.DEPTH(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_result(in_result), .in_ovf(in_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_op(out_op),
    .out_ovf(out_ovf), .out_class(out_class),
    .clr_sticky(clr_sticky), .sticky_ovf(sticky_ovf), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic pop_note;
    if (exp_ret < 15) exp_ret++;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_result = '0; in_ovf = 1'b0;
    out_ready = 1'b0; clr_sticky = 1'b0;
`ifdef FPU_WB_CLASSIFY_EN
    exp_cls = 4'b0100;
`else
    exp_cls = 4'b0000;
`endif
    tick; tick;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_op", 32'(out_op), 0);
    chk("rst_out_ovf", 32'(out_ovf), 0);
    chk("rst_out_class", 32'(out_class), 0);
    chk("rst_sticky", 32'(sticky_ovf), 0);
    chk("rst_retired", 32'(retired_cnt), 0);
    rst_n = 1'b1;
    tick;

    // Single x2 result through an empty FIFO
    in_valid = 1'b1; in_op = 4'd7; in_result = 32'h4000_0000; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_out_data", out_data, 32'h4000_0000);
    chk("lat_out_op", 32'(out_op), 7);
    tick; pop_note();
    chk("lat_retired", 32'(retired_cnt), 1);
    chk("lat_empty", 32'(out_valid), 0);
    chk("lat_hold_data", out_data, 32'h4000_0000);

    // Fill to full under backpressure, then drain in order
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk("fill_in_ready", 32'(in_ready), 1);
      in_valid = 1'b1; in_op = 4'd1; in_result = 32'(i);
      tick;
    end
    chk("full_in_ready", 32'(in_ready), 0);
    in_result = 32'h5;
    tick;
    in_valid = 1'b0;
    chk("full_ignored_ready", 32'(in_ready), 0);
    chk("full_head_stable", out_data, 32'h1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_valid", 32'(out_valid), 1);
      chk("drain_data", out_data, 32'(i));
      tick; pop_note();
    end
    chk("drain_empty", 32'(out_valid), 0);
    chk("drain_retired", 32'(retired_cnt), 32'(exp_ret));

    // Overflowed x2 result with a coincident sticky clear: set wins
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 4'd7; in_result = 32'h7F80_0000; in_ovf = 1'b1; clr_sticky = 1'b1;
    tick;
    in_valid = 1'b0; in_ovf = 1'b0; clr_sticky = 1'b0;
    chk("ovf_sticky_set", 32'(sticky_ovf), 1);
    chk("ovf_out_ovf", 32'(out_ovf), 1);
    chk("ovf_out_data", out_data, 32'h7F80_0000);
    chk("ovf_out_class", 32'(out_class), 32'(exp_cls));
    clr_sticky = 1'b1;
    tick;
    clr_sticky = 1'b0;
    chk("ovf_sticky_clr", 32'(sticky_ovf), 0);
    out_ready = 1'b1;
    tick; pop_note();
    out_ready = 1'b0;
    chk("ovf_retired", 32'(retired_cnt), 32'(exp_ret));

    // Streaming push+pop at depth 2 across pointer wrap
    in_op = 4'd2;
    in_valid = 1'b1; in_result = 32'hA000_0000; tick;
    in_result = 32'hA000_0001; tick;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_result = 32'hA000_0002 + 32'(k);
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_ready", 32'(in_ready), 1);
      chk("stream_data", out_data, 32'hA000_0000 + 32'(k));
      tick; pop_note();
    end
    in_valid = 1'b0;
    chk("tail_data0", out_data, 32'hA000_000A);
    tick; pop_note();
    chk("tail_data1", out_data, 32'hA000_000B);
    tick; pop_note();
    chk("tail_empty", 32'(out_valid), 0);
    chk("stream_retired_sat", 32'(retired_cnt), 32'(exp_ret));

    // 20 further pops with the counter already saturated
    in_valid = 1'b1; in_op = 4'd3;
    for (int k = 0; k < 20; k++) begin
      in_result = 32'hB000_0000 + 32'(k);
      tick;
      if (k > 0) pop_note();
    end
    in_valid = 1'b0;
    chk("sat_last_head", out_data, 32'hB000_0013);
    tick; pop_note();
    chk("sat_retired", 32'(retired_cnt), 32'hF);

    // Reset with three entries queued and sticky set
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_result = 32'hC000_0000 + 32'(i); in_ovf = 1'b1;
      tick;
    end
    in_valid = 1'b0; in_ovf = 1'b0;
    chk("pre_rst_sticky", 32'(sticky_ovf), 1);
    rst_n = 1'b0;
    tick;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_sticky", 32'(sticky_ovf), 0);
    chk("mid_rst_retired", 32'(retired_cnt), 0);
    chk("mid_rst_out_data", out_data, 0);
    rst_n = 1'b1; exp_ret = 0;
    tick;
    in_valid = 1'b1; in_op = 4'd5; in_result = 32'h1234_5678; out_ready = 1'b1;
    tick;
    in_valid = 1'b0;
    chk("post_rst_data", out_data, 32'h1234_5678);
    chk("post_rst_op", 32'(out_op), 5);
    tick; pop_note();
    chk("post_rst_retired", 32'(retired_cnt), 32'(exp_ret));
    chk("post_rst_empty", 32'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
